// File: rtl/mcl_arb_pkg.sv
// Shared types for the MCL transmit credit arbiter.
// State encoding and the output holding-register bundle.
package mcl_arb_pkg;

    // Widest packet the holding register can carry.
    localparam int unsigned mcl_data_max_lp = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                       v;
        logic [mcl_data_max_lp-1:0] data;
    } mcl_hold_s;

endpackage

// File: rtl/mcl_rr_select.sv
// Round-robin priority selector: first request at or above the
// pointer, with wrap. Pure combinational, one-hot grant plus index.
module mcl_rr_select #(
    parameter  int num_req_p    = 3,
    localparam int ptr_width_lp = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]    req_i,
    input  logic [ptr_width_lp-1:0] ptr_i,
    output logic [num_req_p-1:0]    grant_o,
    output logic [ptr_width_lp-1:0] winner_o,
    output logic                    v_o
);

    int                      idx;
    logic [ptr_width_lp-1:0] idx_w;

    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        v_o      = 1'b0;
        idx      = 0;
        idx_w    = '0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
            idx_w = ptr_width_lp'(idx);
            if (!v_o && req_i[idx_w]) begin
                v_o            = 1'b1;
                grant_o[idx_w] = 1'b1;
                winner_o       = idx_w;
            end
        end
    end

endmodule

// File: rtl/mcl_tx_credit_arbiter.sv
// Round-robin, credit-gated arbiter for the host-to-MCL transmit stream.
// Optional MCL_ARB_STATS_EN adds per-requester grant and stall counters.
module mcl_tx_credit_arbiter
    import mcl_arb_pkg::*;
#(
    parameter  int num_req_p         = 3,
    parameter  int mcl_width_p       = 128,
    parameter  int max_out_credits_p = 16,
    localparam int credit_width_lp   = $clog2(max_out_credits_p+1),
    localparam int ptr_width_lp      = $clog2(num_req_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p-1:0]           req_v_i,
    input  logic [num_req_p*mcl_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]           req_ready_o,
    output logic                           mcl_v_o,
    output logic [mcl_width_p-1:0]         mcl_data_o,
    input  logic                           mcl_r_i,
    input  logic                           credit_return_i,
    input  logic                           drain_req_i,
    output logic                           drain_done_o,
    output logic [credit_width_lp-1:0]     credits_o,
    output logic                           error_o
`ifdef MCL_ARB_STATS_EN
   ,output logic [num_req_p*32-1:0]        grant_count_o
   ,output logic [31:0]                    stall_cycles_o
`endif
);

    localparam logic [credit_width_lp-1:0] credits_max_lp =
        credit_width_lp'(max_out_credits_p);

    arb_state_e                state_q, state_d;
    mcl_hold_s                 hold_q, hold_d;
    logic [ptr_width_lp-1:0]   ptr_q, ptr_d;
    logic [credit_width_lp-1:0] credits_q, credits_d;
    logic                      error_q, error_d;

    logic [num_req_p-1:0]      sel_grant;
    logic [ptr_width_lp-1:0]   sel_winner;
    logic                      sel_v;
    logic                      grant_ok;
    logic                      grant_fire;
    logic [credit_width_lp:0]  outstanding;

    mcl_rr_select #(.num_req_p(num_req_p)) u_sel (
        .req_i    (req_v_i),
        .ptr_i    (ptr_q),
        .grant_o  (sel_grant),
        .winner_o (sel_winner),
        .v_o      (sel_v)
    );

    // Drain wins over a grant that would otherwise fire this cycle.
    always_comb begin
        grant_ok = (state_q == SEND) && (credits_q != '0)
                && (!hold_q.v || mcl_r_i) && !drain_req_i;
        grant_fire  = grant_ok && sel_v;
        req_ready_o = grant_ok ? sel_grant : '0;

        hold_d = hold_q;
        if (hold_q.v && mcl_r_i) begin
            hold_d.v = 1'b0;
        end
        if (grant_fire) begin
            hold_d.v    = 1'b1;
            hold_d.data = '0;
            hold_d.data[mcl_width_p-1:0] =
                req_data_i[int'(sel_winner)*mcl_width_p +: mcl_width_p];
        end

        ptr_d = ptr_q;
        if (grant_fire) begin
            ptr_d = (sel_winner == ptr_width_lp'(num_req_p-1))
                  ? '0 : sel_winner + 1'b1;
        end

        credits_d = credits_q;
        error_d   = error_q;
        unique case ({grant_fire, credit_return_i})
            2'b10: credits_d = credits_q - 1'b1;
            2'b01: begin
                if (credits_q == credits_max_lp) begin
                    error_d = 1'b1;
                end else begin
                    credits_d = credits_q + 1'b1;
                end
            end
            default: credits_d = credits_q;
        endcase

        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = SEND;
            SEND: begin
                if (drain_req_i) begin
                    state_d = DRAIN;
                end else if (credits_q == '0 && |req_v_i) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (drain_req_i) begin
                    state_d = DRAIN;
                end else if (credits_q != '0) begin
                    state_d = SEND;
                end
            end
            DRAIN: begin
                if (!drain_req_i) begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            ptr_q     <= '0;
            credits_q <= credits_max_lp;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            error_q   <= error_d;
        end
    end

    // Responses still owed, counting a packet not yet handed to MCL.
    always_comb begin
        outstanding = {1'b0, credits_max_lp} - {1'b0, credits_q}
                    + {credit_width_lp'(0), hold_q.v};
    end

    assign mcl_v_o      = hold_q.v;
    assign mcl_data_o   = hold_q.data[mcl_width_p-1:0];
    assign credits_o    = credits_q;
    assign error_o      = error_q;
    assign drain_done_o = (state_q == DRAIN) && drain_req_i
                       && (outstanding == '0);

`ifdef MCL_ARB_STATS_EN
    logic [num_req_p-1:0][31:0] gcnt_q, gcnt_d;
    logic [31:0]                stall_q, stall_d;

    always_comb begin
        gcnt_d = gcnt_q;
        for (int k = 0; k < num_req_p; k++) begin
            if (grant_fire && sel_grant[k]) begin
                gcnt_d[k] = gcnt_q[k] + 32'd1;
            end
        end
        stall_d = stall_q + {31'd0, (state_q == STALL)};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            gcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            gcnt_q  <= gcnt_d;
            stall_q <= stall_d;
        end
    end

    assign grant_count_o  = gcnt_q;
    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_mcl_tx_credit_arbiter.sv
// Scoreboard bench for mcl_tx_credit_arbiter (3 requesters, 4 credits).
// Directed phases push expected packets; a monitor pops on each transfer.
module tb_mcl_tx_credit_arbiter;
    import mcl_arb_pkg::*;

    localparam int N  = 3;
    localparam int W  = 128;
    localparam int C  = 4;
    localparam int CW = $clog2(C+1);

    logic           clk;
    logic           reset_i;
    logic [N-1:0]   req_v_i;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]   req_ready_o;
    logic           mcl_v_o;
    logic [W-1:0]   mcl_data_o;
    logic           mcl_r_i;
    logic           credit_return_i;
    logic           drain_req_i;
    logic           drain_done_o;
    logic [CW-1:0]  credits_o;
    logic           error_o;
`ifdef MCL_ARB_STATS_EN
    logic [N*32-1:0] grant_count_o;
    logic [31:0]     stall_cycles_o;
`endif

    mcl_tx_credit_arbiter #(
        .num_req_p(N), .mcl_width_p(W), .max_out_credits_p(C)
    ) dut (
`ifdef MCL_ARB_STATS_EN
        .grant_count_o   (grant_count_o),
        .stall_cycles_o  (stall_cycles_o),
`endif
        .clk_i           (clk),
        .reset_i         (reset_i),
        .req_v_i         (req_v_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .mcl_v_o         (mcl_v_o),
        .mcl_data_o      (mcl_data_o),
        .mcl_r_i         (mcl_r_i),
        .credit_return_i (credit_return_i),
        .drain_req_i     (drain_req_i),
        .drain_done_o    (drain_done_o),
        .credits_o       (credits_o),
        .error_o         (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_cmp;
    int           n_bad;
    int           seq  [N];
    int           eseq [N];
    int           nacc [N];
    int           base [N];
    logic [N-1:0] last_acc;
    logic [W-1:0] exp_q [$];

    function automatic logic [W-1:0] mk(input int k, input int s);
        return {32'(k+1), 32'(s), 32'hC0DE_0000 ^ 32'(k), ~32'(s)};
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_data_i[k*W +: W] = mk(k, seq[k]);
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k);
        exp_q.push_back(mk(k, eseq[k]));
        eseq[k]++;
    endtask

    // Samples the handshake for the coming edge, then advances sources.
    task automatic tick();
        logic [N-1:0] acc;
        #2;
        acc = req_v_i & req_ready_o;
        @(negedge clk);
        last_acc = acc;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin
                seq[k]++;
                nacc[k]++;
            end
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        chk("ready_onehot", W'($onehot0(req_ready_o)), 1);
        if (mcl_v_o && mcl_r_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pkt: got %0h expected none",
                         mcl_data_o);
            end else begin
                chk("pkt", mcl_data_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic got;
        n_cmp = 0;
        n_bad = 0;
        for (int k = 0; k < N; k++) begin
            seq[k] = 0; eseq[k] = 0; nacc[k] = 0; base[k] = 0;
        end
        last_acc        = '0;
        reset_i         = 1'b1;
        req_v_i         = '0;
        mcl_r_i         = 1'b0;
        credit_return_i = 1'b0;
        drain_req_i     = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_credits", credits_o, C);
        chk("rst_mcl_v", mcl_v_o, 0);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_done", drain_done_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_state", dut.state_q, IDLE);
        reset_i = 1'b0;

        // Single requester exhausts the credit pool.
        mcl_r_i = 1'b1;
        req_v_i = 3'b001;
        repeat (4) push(0);
        repeat (12) tick();
        chk("t1_accepts", nacc[0], 4);
        chk("t1_credits", credits_o, 0);
        chk("t1_state", dut.state_q, STALL);
        chk("t1_empty", mcl_v_o, 0);
        push(0);
        credit_return_i = 1'b1;
        tick();
        credit_return_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = last_acc[0];
        end
        chk("t1_fifth_accept", got, 1);
        chk("t1_fifth_latency", mcl_v_o, 1);
        req_v_i = '0;
        repeat (2) tick();
        credit_return_i = 1'b1;
        repeat (4) tick();
        credit_return_i = 1'b0;
        chk("t1_refill", credits_o, C);
        chk("t1_error", error_o, 0);

        // Fairness with a return every cycle; pointer sits at 1.
        for (int k = 0; k < N; k++) base[k] = nacc[k];
        for (int i = 0; i < 300; i++) push((1 + i) % N);
        req_v_i = 3'b111;
        credit_return_i = 1'b1;
        repeat (300) tick();
        req_v_i = '0;
        credit_return_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("t2_share", nacc[k] - base[k], 100);
        end
        repeat (2) tick();
        chk("t2_credits", credits_o, C);
        chk("t2_error", error_o, 0);

        // Backpressure holds the packet and blocks new grants.
        base[0] = nacc[0];
        push(0);
        req_v_i = 3'b001;
        mcl_r_i = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t3_no_ready", req_ready_o, 0);
            tick();
            chk("t3_hold_v", mcl_v_o, 1);
            chk("t3_hold_data", mcl_data_o, mk(0, eseq[0] - 1));
        end
        chk("t3_credits", credits_o, C - 1);
        chk("t3_one_accept", nacc[0] - base[0], 1);
        req_v_i = '0;
        mcl_r_i = 1'b1;
        tick();
        credit_return_i = 1'b1;
        tick();
        credit_return_i = 1'b0;
        chk("t3_refill", credits_o, C);

        // Drain with three outstanding.
        repeat (3) push(0);
        req_v_i = 3'b001;
        repeat (3) tick();
        chk("t4_credits", credits_o, C - 3);
        drain_req_i = 1'b1;
        req_v_i = 3'b111;
        #1;
        chk("t4_drain_priority", req_ready_o, 0);
        tick();
        chk("t4_state", dut.state_q, DRAIN);
        credit_return_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_not_done", drain_done_o, 0);
            chk("t4_no_ready", req_ready_o, 0);
            tick();
        end
        credit_return_i = 1'b0;
        chk("t4_done", drain_done_o, 1);
        chk("t4_credits_max", credits_o, C);
        tick();
        chk("t4_done_hold", drain_done_o, 1);
        drain_req_i = 1'b0;
        #1;
        chk("t4_done_drop", drain_done_o, 0);
        push(1);
        tick();
        chk("t4_no_grant_exit", last_acc, 0);
        tick();
        chk("t4_resume_ptr", last_acc, 3'b010);
        req_v_i = '0;
        tick();
        credit_return_i = 1'b1;
        tick();
        credit_return_i = 1'b0;
        chk("t4_refill", credits_o, C);

        // Return at full pool saturates and latches the error.
        credit_return_i = 1'b1;
        tick();
        credit_return_i = 1'b0;
        chk("t5_saturate", credits_o, C);
        chk("t5_error", error_o, 1);
        repeat (3) tick();
        chk("t5_error_sticky", error_o, 1);

        // Asynchronous reset between edges discards the held packet.
        req_v_i = 3'b001;
        mcl_r_i = 1'b0;
        tick();
        req_v_i = '0;
        chk("t6_held", mcl_v_o, 1);
        chk("t6_credits", credits_o, C - 1);
        #1;
        reset_i = 1'b1;
        #1;
        chk("t6_async_v", mcl_v_o, 0);
        chk("t6_async_credits", credits_o, C);
        chk("t6_async_error", error_o, 0);
        tick();
        reset_i = 1'b0;
        mcl_r_i = 1'b1;
        repeat (2) tick();
        chk("t6_state", dut.state_q, SEND);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
